// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus responder: IO window, register
// offsets and the controller state encoding.
package mio_pkg;

   localparam logic [3:0] IO_BASE = 4'hF;

   localparam logic [1:0] REG_LED = 2'd0;
   localparam logic [1:0] REG_TMR = 2'd1;
   localparam logic [1:0] REG_CMP = 2'd2;
   localparam logic [1:0] REG_IRQ = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RAM_WAIT = 2'd1,
      ST_DONE     = 2'd2
   } mio_state_t;

   // True when the top address nibble selects the IO register window.
   function automatic logic is_io(input logic [3:0] addr_nib);
      return addr_nib == IO_BASE;
   endfunction

endpackage

// File: rtl/mio_timer.sv
// Free-running 32-bit timer with a compare register and a sticky match
// interrupt. Load and clear strobes come from the bus responder.
module mio_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        tmr_ld,
   input  logic [31:0] tmr_val,
   input  logic        cmp_ld,
   input  logic [31:0] cmp_val,
   input  logic        irq_clr,
   output logic [31:0] timer,
   output logic [31:0] compare,
   output logic        irq
);

   // Timer counts every cycle; a software load wins over the increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timer <= '0;
      else if (tmr_ld)
         timer <= tmr_val;
      else
         timer <= timer + 32'd1;
   end

   // Compare resets to all-ones so the interrupt stays quiet until programmed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         compare <= 32'hFFFF_FFFF;
      else if (cmp_ld)
         compare <= cmp_val;
   end

   // Sticky match flag; a clear in the same cycle as a match wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         irq <= 1'b0;
      else if (irq_clr)
         irq <= 1'b0;
      else if (timer == compare)
         irq <= 1'b1;
   end

endmodule

// File: rtl/mio_bus_responder.sv
// Responder end of the CPU memory/IO bus. Accepts one word request at a
// time, routes it to block RAM or the IO register bank, and returns read
// data with a single-cycle ready strobe.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for req; request latched and RAM strobes issued on accept
// RAM_WAIT  | RAM load in flight, counting down the read latency
// DONE      | completion cycle: IO writes commit, read data captured, ready set
module mio_bus_responder
   import mio_pkg::*;
#(
   parameter int RAM_LAT = 2,
   parameter int RAM_AW  = 10,
   parameter int LED_W   = 8,
   parameter int SW_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [SW_W-1:0]   sw_i,
   output logic [LED_W-1:0]  led_o,
   output logic              irq_o
);

   mio_state_t        state;
   mio_state_t        state_nx;

   logic              accept;
   logic              req_io;
   logic              lat_io;
   logic              lat_we;
   logic [1:0]        lat_reg;
   logic [31:0]       lat_wdata;
   logic [3:0]        wait_cnt;

   logic [SW_W-1:0]   sw_meta;
   logic [SW_W-1:0]   sw_sync;

   logic              io_wr;
   logic              tmr_ld;
   logic              cmp_ld;
   logic              irq_clr;
   logic [31:0]       io_rdata;

   logic [31:0]       timer;
   logic [31:0]       compare;
   logic              irq;

   // Only the window nibble, the RAM index and the register select are
   // decoded; remaining address bits are intentionally don't-care.
   logic              unused_addr;
   assign unused_addr = ^addr;

   // No new accept in the ready cycle: the CPU still holds the completed
   // request there, so accepting would replay it.
   assign accept = (state == ST_IDLE) && req && !ready;
   assign req_io = is_io(addr[31:28]);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Next-state and IO write strobes.
   always_comb begin
      state_nx = state;
      io_wr    = 1'b0;
      tmr_ld   = 1'b0;
      cmp_ld   = 1'b0;
      irq_clr  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (req_io || we)
                  state_nx = ST_DONE;
               else
                  state_nx = ST_RAM_WAIT;
            end
         end
         ST_RAM_WAIT: begin
            if (wait_cnt <= 4'd1)
               state_nx = ST_DONE;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
            io_wr    = lat_io && lat_we;
            tmr_ld   = io_wr && (lat_reg == REG_TMR);
            cmp_ld   = io_wr && (lat_reg == REG_CMP);
            irq_clr  = io_wr && (lat_reg == REG_IRQ);
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Latch the request on accept; decode downstream uses the latched copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_io    <= 1'b0;
         lat_we    <= 1'b0;
         lat_reg   <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_io    <= req_io;
         lat_we    <= we;
         lat_reg   <= addr[3:2];
         lat_wdata <= wdata;
      end
   end

   // Load-latency down-counter, armed on every accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (accept)
         wait_cnt <= 4'(RAM_LAT);
      else if (state == ST_RAM_WAIT && wait_cnt != 4'd0)
         wait_cnt <= wait_cnt - 4'd1;
   end

   // RAM port: address held until the next RAM accept, write strobe one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
      end else begin
         ram_we <= accept && !req_io && we;
         if (accept && !req_io) begin
            ram_addr <= addr[RAM_AW+1:2];
            if (we)
               ram_wdata <= wdata;
         end
      end
   end

   // Two-flop synchroniser for the asynchronous board switches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_i;
         sw_sync <= sw_meta;
      end
   end

   // IO read mux, aliased by the register select bits.
   always_comb begin
      io_rdata = '0;
      case (lat_reg)
         REG_LED: io_rdata = 32'(sw_sync);
         REG_TMR: io_rdata = timer;
         REG_CMP: io_rdata = compare;
         REG_IRQ: io_rdata = {31'b0, irq};
         default: io_rdata = '0;
      endcase
   end

   // Completion: ready pulse and read-data capture; stores keep old rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready <= 1'b0;
         rdata <= '0;
      end else begin
         ready <= (state == ST_DONE);
         if (state == ST_DONE && !lat_we)
            rdata <= lat_io ? io_rdata : ram_rdata;
      end
   end

   // LED register, written only when the transaction completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         led_o <= '0;
      else if (io_wr && lat_reg == REG_LED)
         led_o <= lat_wdata[LED_W-1:0];
   end

   mio_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .tmr_ld  (tmr_ld),
      .tmr_val (lat_wdata),
      .cmp_ld  (cmp_ld),
      .cmp_val (lat_wdata),
      .irq_clr (irq_clr),
      .timer   (timer),
      .compare (compare),
      .irq     (irq)
   );

   assign irq_o = irq;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed vector table, hand
// sequences for timer/irq, back-to-back, reset abort, then random traffic
// against a transaction-level reference model.
module tb_mio_bus_responder;

   localparam int RAM_LAT   = 2;
   localparam int RAM_AW    = 10;
   localparam int LED_W     = 8;
   localparam int SW_W      = 8;
   localparam int RAM_WORDS = 1 << RAM_AW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req = 1'b0;
   logic              we = 1'b0;
   logic [31:0]       addr = '0;
   logic [31:0]       wdata = '0;
   logic [31:0]       rdata;
   logic              ready;
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic [SW_W-1:0]   sw_i = '0;
   logic [LED_W-1:0]  led_o;
   logic              irq_o;

   mio_bus_responder #(
      .RAM_LAT (RAM_LAT),
      .RAM_AW  (RAM_AW),
      .LED_W   (LED_W),
      .SW_W    (SW_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .sw_i      (sw_i),
      .led_o     (led_o),
      .irq_o     (irq_o)
   );

   always #5 clk = ~clk;

   // cycle index; cycle n lies between rising edges n-1 and n
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM macro: fixed read pipeline of RAM_LAT cycles, synchronous write
   logic [31:0]       env_mem [RAM_WORDS];
   logic [RAM_AW-1:0] rd_pipe [RAM_LAT] = '{default: '0};
   bit                env_init = 1'b0;
   always @(posedge clk) begin
      if (!env_init) begin
         for (int i = 0; i < RAM_WORDS; i++) env_mem[i] <= '0;
         env_init <= 1'b1;
      end else if (ram_we) begin
         env_mem[ram_addr] <= ram_wdata;
      end
      rd_pipe[0] <= ram_addr;
      for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = env_mem[rd_pipe[RAM_LAT-1]];

   // ram_we observer
   int we_cnt = 0;
   int we_last = -1;
   always @(negedge clk) begin
      if (ram_we) begin
         we_cnt  <= we_cnt + 1;
         we_last <= cyc;
      end
   end

   // reference model state
   logic [31:0]      ref_mem [RAM_WORDS];
   logic [31:0]      m_rdata;
   logic [LED_W-1:0] m_led;
   logic [SW_W-1:0]  m_sw;
   logic [31:0]      m_cmp;
   logic             m_irq;
   logic [31:0]      m_tbase;
   int               m_tcyc;

   int n_chk = 0;
   int n_err = 0;

   function automatic logic [31:0] tmr_at(input int c);
      return m_tbase + 32'(c - m_tcyc);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_rdata = '0;
      m_led   = '0;
      m_cmp   = 32'hFFFF_FFFF;
      m_irq   = 1'b0;
      m_tbase = '0;
      m_tcyc  = cyc;
   endtask

   // One complete transaction, started at posedge+1, returns at posedge+1
   // of the cycle after ready with req dropped.
   task automatic do_op(input string nm, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
      int s, wc0, idx, exp_lat;
      logic io;
      logic [1:0] rg;
      logic [31:0] exp;
      io  = (a[31:28] == 4'hF);
      rg  = a[3:2];
      idx = int'((a >> 2) % RAM_WORDS);
      s   = cyc;
      wc0 = we_cnt;
      exp_lat = (!io && !w) ? RAM_LAT + 2 : 2;
      if (w)
         exp = m_rdata;
      else if (!io)
         exp = ref_mem[idx];
      else begin
         case (rg)
            2'd0:    exp = 32'(m_sw);
            2'd1:    exp = tmr_at(s + 1);
            2'd2:    exp = m_cmp;
            default: exp = {31'b0, m_irq};
         endcase
      end
      req = 1'b1; we = w; addr = a; wdata = d;
      lat = -1;
      rd  = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready) begin
            lat = cyc - s;
            rd  = rdata;
            break;
         end
      end
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      chk({nm, " ready single"}, 32'(ready), 32'd0);
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " rdata"}, rd, exp);
      if (!w)
         m_rdata = exp;
      else if (!io)
         ref_mem[idx] = d;
      else begin
         case (rg)
            2'd0:    m_led = d[LED_W-1:0];
            2'd1:    begin m_tbase = d; m_tcyc = s + 2; end
            2'd2:    m_cmp = d;
            default: m_irq = 1'b0;
         endcase
      end
      if (!io) chk({nm, " ram_addr"}, 32'(ram_addr), 32'(idx));
      if (w && !io) begin
         chk({nm, " ram_we count"}, 32'(we_cnt - wc0), 32'd1);
         chk({nm, " ram_we cycle"}, 32'(we_last), 32'(s + 1));
         chk({nm, " ram_wdata"}, ram_wdata, d);
      end else begin
         chk({nm, " no ram_we"}, 32'(we_cnt - wc0), 32'd0);
      end
      if (w && io && rg == 2'd0) chk({nm, " led"}, 32'(led_o), 32'(m_led));
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t tbl [13];

   initial begin : main
      logic [31:0] rd;
      int lat, s, s2, s3, first_irq, n_rdy, r1, r2, n_hi;
      logic [31:0] cmpv, a;
      int op;

      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] rd;
      int lat, s, s2, s3, first_irq, n_rdy, r1, r2, n_hi;
      logic [31:0] cmpv, a;
      int op;

      tbl[0]  = '{1'b0, 32'hF000_0008, 32'h0,         32'hFFFF_FFFF, 2};
      tbl[1]  = '{1'b0, 32'hF000_000C, 32'h0,         32'h0000_0000, 2};
      tbl[2]  = '{1'b0, 32'hF000_0000, 32'h0,         32'h0000_003C, 2};
      tbl[3]  = '{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_003C, 2};
      tbl[4]  = '{1'b0, 32'h0000_0014, 32'h0,         32'hDEAD_BEEF, RAM_LAT + 2};
      tbl[5]  = '{1'b1, 32'h0000_1008, 32'h1234_5678, 32'hDEAD_BEEF, 2};
      tbl[6]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, RAM_LAT + 2};
      tbl[7]  = '{1'b0, 32'h0000_4008, 32'h0,         32'h1234_5678, RAM_LAT + 2};
      tbl[8]  = '{1'b1, 32'hF000_0000, 32'h0000_00A5, 32'h1234_5678, 2};
      tbl[9]  = '{1'b0, 32'hF000_0010, 32'h0,         32'h0000_003C, 2};
      tbl[10] = '{1'b1, 32'hF000_0008, 32'h0000_1234, 32'h0000_003C, 2};
      tbl[11] = '{1'b0, 32'hF000_0018, 32'h0,         32'h0000_1234, 2};
      tbl[12] = '{1'b0, 32'hF000_001C, 32'h0,         32'h0000_0000, 2};

      for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = '0;
      sw_i = 8'h3C;
      m_sw = 8'h3C;

      // reset and reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("reset ready", 32'(ready), 32'd0);
      chk("reset ram_we", 32'(ram_we), 32'd0);
      chk("reset rdata", rdata, 32'd0);
      chk("reset ram_addr", 32'(ram_addr), 32'd0);
      chk("reset ram_wdata", ram_wdata, 32'd0);
      chk("reset led", 32'(led_o), 32'd0);
      chk("reset irq", 32'(irq_o), 32'd0);
      @(posedge clk); #1;

      // directed vector table
      for (int i = 0; i < 13; i++) begin
         do_op($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, rd, lat);
         chk($sformatf("vec%0d table rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d table latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      end
      chk("led after A5", 32'(led_o), 32'h0000_00A5);

      // timer compare interrupt
      do_op("irq tmr1000", 1'b1, 32'hF000_0004, 32'd1000, rd, lat);
      do_op("irq cmp50", 1'b1, 32'hF000_0008, 32'd50, rd, lat);
      do_op("irq clr0", 1'b1, 32'hF000_000C, 32'd0, rd, lat);
      chk("irq low before", 32'(irq_o), 32'd0);
      s = cyc;
      do_op("irq tmr40", 1'b1, 32'hF000_0004, 32'd40, rd, lat);
      first_irq = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (irq_o) begin first_irq = cyc; break; end
      end
      chk("irq rise cycle", 32'(first_irq), 32'(s + 13));
      n_hi = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (irq_o) n_hi++;
      end
      chk("irq sticky", 32'(n_hi), 32'd5);
      m_irq = 1'b1;
      @(posedge clk); #1;
      do_op("irq read1", 1'b0, 32'hF000_000C, 32'd0, rd, lat);
      chk("irq read1 value", rd, 32'd1);
      // clear lands in the cycle where timer equals compare
      s2 = cyc;
      cmpv = tmr_at(s2 + 4);
      do_op("irq cmp hit", 1'b1, 32'hF000_0008, cmpv, rd, lat);
      s3 = cyc;
      chk("irq clear staging", 32'(s3), 32'(s2 + 3));
      do_op("irq clr hit", 1'b1, 32'hF000_000C, 32'd0, rd, lat);
      chk("irq clear wins", 32'(irq_o), 32'd0);
      do_op("irq read0", 1'b0, 32'hF000_000C, 32'd0, rd, lat);
      chk("irq read0 value", rd, 32'd0);

      // timer wrap
      do_op("wrap load", 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, lat);
      do_op("wrap rd1", 1'b0, 32'hF000_0004, 32'd0, rd, lat);
      chk("wrap rd1 value", rd, 32'h0000_0000);
      do_op("wrap rd2", 1'b0, 32'hF000_0004, 32'd0, rd, lat);
      chk("wrap rd2 value", rd, 32'h0000_0003);

      // back-to-back: req held across two switch reads
      s = cyc;
      req = 1'b1; we = 1'b0; addr = 32'hF000_0000;
      n_rdy = 0; r1 = -1; r2 = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ready) begin
            n_rdy++;
            if (n_rdy == 1) r1 = cyc; else r2 = cyc;
            chk("b2b rdata", rdata, 32'(m_sw));
         end
         if (k == 5) req = 1'b0;
      end
      chk("b2b ready count", 32'(n_rdy), 32'd2);
      chk("b2b ready1 cycle", 32'(r1), 32'(s + 2));
      chk("b2b ready2 cycle", 32'(r2), 32'(s + 5));
      m_rdata = 32'(m_sw);
      @(posedge clk); #1;

      // reset during RAM_WAIT
      req = 1'b1; we = 1'b0; addr = 32'h0000_0014;
      @(posedge clk); #3;
      rst = 1'b1;
      req = 1'b0;
      #1;
      chk("abort ready", 32'(ready), 32'd0);
      chk("abort ram_we", 32'(ram_we), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      n_rdy = 0;
      repeat (8) begin
         @(negedge clk);
         if (ready) n_rdy++;
      end
      chk("abort no ready", 32'(n_rdy), 32'd0);
      chk("abort led", 32'(led_o), 32'd0);
      chk("abort rdata", rdata, 32'd0);
      chk("abort ram_addr", 32'(ram_addr), 32'd0);
      @(posedge clk); #1;
      do_op("post reset load", 1'b0, 32'h0000_0014, 32'd0, rd, lat);
      chk("post reset value", rd, 32'hDEAD_BEEF);

      // random traffic
      for (int i = 0; i < 200; i++) begin
         op = int'($urandom_range(0, 6));
         case (op)
            0: begin
               a = {4'($urandom_range(0, 14)), 28'($urandom)};
               do_op("rnd store", 1'b1, a, $urandom, rd, lat);
            end
            1, 2: begin
               a = {4'($urandom_range(0, 14)), 28'($urandom)};
               do_op("rnd load", 1'b0, a, 32'd0, rd, lat);
            end
            3: begin
               a = {4'hF, 24'($urandom), 2'd0, 2'($urandom)};
               do_op("rnd led", 1'b1, a, $urandom, rd, lat);
            end
            4: begin
               sw_i = 8'($urandom);
               m_sw = sw_i;
               repeat (3) @(posedge clk);
               #1;
               a = {4'hF, 24'($urandom), 2'd0, 2'($urandom)};
               do_op("rnd sw", 1'b0, a, 32'd0, rd, lat);
            end
            5: begin
               a = {4'hF, 24'($urandom), 2'd1, 2'($urandom)};
               do_op("rnd tmr", 1'b0, a, 32'd0, rd, lat);
            end
            default: begin
               a = {4'hF, 24'($urandom), 2'd2, 2'($urandom)};
               do_op("rnd cmp wr", 1'b1, a, $urandom, rd, lat);
               do_op("rnd cmp rd", 1'b0, a, 32'd0, rd, lat);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
